data_mem_bytelane: RTL

Parametrised 32-bit RV32I data memory with byte-lane stores, sign/zero-extending sub-word loads, a valid/ready request port and a single-cycle response pulse. It replaces the word-only combinational-read data memory in the load/store path. It adds:
- configurable wait states;
- a hardware clear sequence after reset;
- range and size error reporting.

The LSU issues one request at a time and consumes the response.

---
 rtl/data_mem_bytelane.sv | 279 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/data_mem_bytelane.sv
// data_mem_bytelane: RV32I data memory with byte-lane stores and sign/zero-
// extending sub-word loads behind a valid/ready request port. Each accepted
// request produces exactly one single-cycle response pulse.
//
// Parameters:
//   ADDR_WIDTH     byte-address width of i_ReqAddr
//   DEPTH_WORDS    number of 32-bit words (power of two, >= 4)
//   WAIT_STATES    extra cycles between accept and response (0..15)
//   CLEAR_ON_RESET 1: zero every word after reset; 0: contents survive reset
//   INIT_FILE      preload image path. This RTL does not load it; a non-empty
//                  path raises an elaboration warning so the memory wrapper
//                  that owns preloading is not forgotten.
//
// Optional feature macro: DMEM_MISALIGN_CHECK_EN
//   defined   - misaligned half/word accesses are rejected with o_RspErr
//   undefined - misaligned half/word accesses are force-aligned, no error
//
// Ports:
//   clk, reset              clock; asynchronous active-high reset
//   i_ReqValid/o_ReqReady   request handshake (ready only in IDLE)
//   i_ReqWe                 1 = store, 0 = load
//   i_ReqAddr               byte address
//   i_ReqSize               00 byte, 01 half, 10 word, 11 reserved (error)
//   i_ReqUnsigned           zero-extend sub-word loads when 1
//   i_ReqWData              right-aligned store data
//   o_RspValid              one-cycle response pulse
//   o_RspRData              extended load data; 0 for stores and errors
//   o_RspErr                request rejected (range/size/alignment)
//   o_Busy                  state is not IDLE
module data_mem_bytelane #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DEPTH_WORDS    = 1024,
  parameter int unsigned WAIT_STATES    = 0,
  parameter bit          CLEAR_ON_RESET = 1'b1,
  parameter string       INIT_FILE      = ""
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_ReqValid,
  output logic                  o_ReqReady,
  input  logic                  i_ReqWe,
  input  logic [ADDR_WIDTH-1:0] i_ReqAddr,
  input  logic [1:0]            i_ReqSize,
  input  logic                  i_ReqUnsigned,
  input  logic [31:0]           i_ReqWData,
  output logic                  o_RspValid,
  output logic [31:0]           o_RspRData,
  output logic                  o_RspErr,
  output logic                  o_Busy
);

  localparam int unsigned IDX_W  = $clog2(DEPTH_WORDS);
  localparam int unsigned WIDX_W = ADDR_WIDTH - 2;
  localparam int unsigned WCNT_W = 4;

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_IDLE  = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  typedef struct packed {
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [1:0]            size;
    logic                  uns;
    logic [31:0]           wdata;
  } req_t;

  localparam state_e RESET_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;

  // Elaboration-time parameter sanity.
  if (WAIT_STATES > 15) begin : g_bad_wait
    $error("data_mem_bytelane: WAIT_STATES must be 0..15");
  end
  if (DEPTH_WORDS < 4 || (DEPTH_WORDS & (DEPTH_WORDS - 1)) != 0) begin : g_bad_depth
    $error("data_mem_bytelane: DEPTH_WORDS must be a power of two >= 4");
  end
  if (INIT_FILE != "") begin : g_init_note
    $warning("data_mem_bytelane: INIT_FILE is not loaded by this RTL");
  end

  // State and datapath registers.
  state_e                state_q, state_d;
  logic [IDX_W-1:0]      clr_cnt_q, clr_cnt_d;
  logic [WCNT_W-1:0]     wait_cnt_q, wait_cnt_d;
  req_t                  req_q, req_d;
  logic [31:0]           rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_err_q, rsp_err_d;
  logic [31:0]           mem_q [DEPTH_WORDS];

  // Combinational decode of the request being committed.
  req_t                  req_in_c;
  req_t                  req_c;
  logic [WIDX_W-1:0]     word_full_c;
  logic [IDX_W-1:0]      idx_c;
  logic [1:0]            lane_c;
  logic                  range_err_c;
  logic                  size_err_c;
  logic                  align_err_c;
  logic                  err_c;
  logic [3:0]            be_c;
  logic [31:0]           wdata_al_c;
  logic [31:0]           rd_word_c;
  logic [7:0]            byte_c;
  logic [15:0]           half_c;
  logic [31:0]           load_c;
  logic                  commit_c;
  logic                  clr_we_c;
  logic                  wr_en_c;

  // Pack the incoming request fields.
  always_comb begin
    req_in_c       = '0;
    req_in_c.we    = i_ReqWe;
    req_in_c.addr  = i_ReqAddr;
    req_in_c.size  = i_ReqSize;
    req_in_c.uns   = i_ReqUnsigned;
    req_in_c.wdata = i_ReqWData;
  end

  // With zero wait states the commit edge is also the accept edge, so the
  // request is taken straight from the port; otherwise from the latch.
  always_comb begin
    req_c = (state_q == ST_IDLE) ? req_in_c : req_q;
  end

  // Address/size decode, error detection, lane enables and load extraction.
  always_comb begin
    word_full_c = req_c.addr[ADDR_WIDTH-1:2];
    idx_c       = word_full_c[IDX_W-1:0];
    lane_c      = req_c.addr[1:0];
    range_err_c = 64'(word_full_c) >= 64'(DEPTH_WORDS);
    size_err_c  = (req_c.size == 2'b11);
`ifdef DMEM_MISALIGN_CHECK_EN
    align_err_c = ((req_c.size == 2'b01) && req_c.addr[0]) ||
                  ((req_c.size == 2'b10) && (req_c.addr[1:0] != 2'b00));
`else
    align_err_c = 1'b0;
`endif
    err_c = range_err_c || size_err_c || align_err_c;

    be_c       = 4'b0000;
    wdata_al_c = req_c.wdata;
    case (req_c.size)
      2'b00: begin
        be_c       = 4'b0001 << lane_c;
        wdata_al_c = {4{req_c.wdata[7:0]}};
      end
      2'b01: begin
        // Half accesses ignore addr[0] when not rejected for misalignment.
        be_c       = lane_c[1] ? 4'b1100 : 4'b0011;
        wdata_al_c = {2{req_c.wdata[15:0]}};
      end
      2'b10: begin
        be_c       = 4'b1111;
        wdata_al_c = req_c.wdata;
      end
      default: begin
        be_c       = 4'b0000;
        wdata_al_c = req_c.wdata;
      end
    endcase

    rd_word_c = mem_q[idx_c];
    byte_c    = rd_word_c[{lane_c, 3'b000} +: 8];
    half_c    = rd_word_c[{lane_c[1], 4'b0000} +: 16];
    case (req_c.size)
      2'b00:   load_c = req_c.uns ? {24'h0, byte_c} : {{24{byte_c[7]}}, byte_c};
      2'b01:   load_c = req_c.uns ? {16'h0, half_c} : {{16{half_c[15]}}, half_c};
      2'b10:   load_c = rd_word_c;
      default: load_c = 32'h0;
    endcase
  end

  // Next-state and register-update logic.
  always_comb begin
    state_d     = state_q;
    clr_cnt_d   = clr_cnt_q;
    wait_cnt_d  = wait_cnt_q;
    req_d       = req_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    commit_c    = 1'b0;
    clr_we_c    = 1'b0;

    case (state_q)
      ST_CLEAR: begin
        clr_we_c = 1'b1;
        if (clr_cnt_q == IDX_W'(DEPTH_WORDS - 1)) begin
          clr_cnt_d = '0;
          state_d   = ST_IDLE;
        end else begin
          clr_cnt_d = clr_cnt_q + IDX_W'(1);
        end
      end
      ST_IDLE: begin
        if (i_ReqValid) begin
          req_d = req_in_c;
          if (WAIT_STATES == 0) begin
            state_d  = ST_RESP;
            commit_c = 1'b1;
          end else begin
            state_d    = ST_WAIT;
            wait_cnt_d = WCNT_W'(WAIT_STATES - 1);
          end
        end
      end
      ST_WAIT: begin
        if (wait_cnt_q == '0) begin
          state_d  = ST_RESP;
          commit_c = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q - WCNT_W'(1);
        end
      end
      ST_RESP: begin
        // Response data is only meaningful with o_RspValid; return to zero.
        state_d     = ST_IDLE;
        rsp_rdata_d = '0;
        rsp_err_d   = 1'b0;
      end
      default: begin
        state_d = RESET_STATE;
      end
    endcase

    // Load read and response capture happen on the edge that enters RESP.
    if (commit_c) begin
      rsp_err_d   = err_c;
      rsp_rdata_d = (err_c || req_c.we) ? 32'h0 : load_c;
    end
  end

  assign wr_en_c = commit_c && req_c.we && !err_c;

  // Control registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= RESET_STATE;
      clr_cnt_q   <= '0;
      wait_cnt_q  <= '0;
      req_q       <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_cnt_q   <= clr_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      req_q       <= req_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Storage array: not reset; written by the clear sweep or a committed store.
  // Both enables derive from the asynchronously reset state, so a reset
  // landing mid-request suppresses the pending write.
  always_ff @(posedge clk) begin
    if (clr_we_c) begin
      mem_q[clr_cnt_q] <= '0;
    end else if (wr_en_c) begin
      for (int b = 0; b < 4; b++) begin
        if (be_c[b]) begin
          mem_q[idx_c][8*b +: 8] <= wdata_al_c[8*b +: 8];
        end
      end
    end
  end

  // Status outputs decoded from the state register.
  assign o_ReqReady = (state_q == ST_IDLE);
  assign o_Busy     = (state_q != ST_IDLE);
  assign o_RspValid = (state_q == ST_RESP);
  assign o_RspRData = rsp_rdata_q;
  assign o_RspErr   = rsp_err_q;

endmodule
